// File: rtl/ecc_scrub_ctrl.sv
// Background SECDED scrubber: walks a 39-bit ECC array over a shared req/gnt port and counts errors.
// Define ECC_SCRUB_WRITEBACK_EN to write corrected words back; otherwise the block only reports.
module ecc_scrub_ctrl #(
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cnt_clr,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [38:0]           mem_wdata,
    input  logic [38:0]           mem_rdata,
    output logic                  err_corr,
    output logic                  err_uncorr,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [15:0]           corr_cnt,
    output logic [15:0]           uncorr_cnt,
    output logic                  pass_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RD, S_RDATA, S_CHK
`ifdef ECC_SCRUB_WRITEBACK_EN
        , S_WR
`endif
    } state_t;

    // Hamming check bits 6..1; data bit k sits at the k-th non-power-of-two codeword position.
    function automatic logic [6:1] ham(input logic [31:0] d);
        logic [38:1] cw;
        logic [6:1]  h;
        int          k;
        cw = '0;
        h  = '0;
        k  = 0;
        for (int pos = 3; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[k];
                k++;
            end
        end
        for (int i = 1; i <= 6; i++)
            for (int pos = 1; pos <= 38; pos++)
                if (pos[i-1]) h[i] = h[i] ^ cw[pos];
        return h;
    endfunction

`ifdef ECC_SCRUB_WRITEBACK_EN
    function automatic logic [6:0] encode(input logic [31:0] d);
        logic [6:1] h;
        h = ham(d);
        return {h, ^{d, h}};
    endfunction

    function automatic logic [31:0] correct(input logic [31:0] d, input logic [6:1] s);
        logic [31:0] r;
        int          k;
        r = d;
        k = 0;
        for (int pos = 3; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (s == 6'(pos)) r[k] = ~r[k];
                k++;
            end
        end
        return r;
    endfunction
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           ivl_q, ivl_d;
    logic [38:0]           word_q, word_d;
    logic                  req_q, req_d;
    logic                  err_corr_q, err_corr_d;
    logic                  err_uncorr_q, err_uncorr_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [15:0]           corr_cnt_q, corr_cnt_d;
    logic [15:0]           uncorr_cnt_q, uncorr_cnt_d;
    logic                  pass_done_q, pass_done_d;
    logic                  advance;

    logic [31:0] word_data;
    logic [6:1]  syn;
    logic        par, is_corr, is_uncorr;

    assign word_data = word_q[38:7];
    assign syn       = ham(word_data) ^ word_q[6:1];
    assign par       = ^word_q;
    // With odd parity every syndrome that names a real codeword position is a single-bit error.
    assign is_corr   = par & (syn <= 6'd38);
    assign is_uncorr = (par & (syn > 6'd38)) | (~par & (syn != 6'd0));

`ifdef ECC_SCRUB_WRITEBACK_EN
    logic        we_q, we_d;
    logic [38:0] wdata_q, wdata_d;
    logic [31:0] corr_data;
    assign corr_data = correct(word_data, syn);
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        ivl_d        = ivl_q;
        word_d       = word_q;
        req_d        = req_q;
        err_corr_d   = 1'b0;
        err_uncorr_d = 1'b0;
        err_addr_d   = err_addr_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        pass_done_d  = 1'b0;
        advance      = 1'b0;
`ifdef ECC_SCRUB_WRITEBACK_EN
        we_d         = we_q;
        wdata_d      = wdata_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WAIT;
                    ivl_d   = 16'(SCRUB_INTERVAL);
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (ivl_q == 16'd0) begin
                    state_d = S_RD;
                    req_d   = 1'b1;
                end else begin
                    ivl_d = ivl_q - 16'd1;
                end
            end
            S_RD: begin
                if (mem_gnt) begin
                    state_d = S_RDATA;
                    req_d   = 1'b0;
                end else if (!enable) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
            S_RDATA: begin
                word_d  = mem_rdata;
                state_d = S_CHK;
            end
            S_CHK: begin
                err_corr_d   = is_corr;
                err_uncorr_d = is_uncorr;
                if (is_corr || is_uncorr) err_addr_d = addr_q;
                if (is_corr && corr_cnt_q != 16'hFFFF) corr_cnt_d = corr_cnt_q + 16'd1;
                if (is_uncorr && uncorr_cnt_q != 16'hFFFF) uncorr_cnt_d = uncorr_cnt_q + 16'd1;
`ifdef ECC_SCRUB_WRITEBACK_EN
                if (is_corr) begin
                    state_d = S_WR;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = {corr_data, encode(corr_data)};
                end else begin
                    advance = 1'b1;
                end
`else
                advance = 1'b1;
`endif
            end
`ifdef ECC_SCRUB_WRITEBACK_EN
            S_WR: begin
                if (mem_gnt) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    advance = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                addr_d      = '0;
                pass_done_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
            state_d = enable ? S_WAIT : S_IDLE;
            ivl_d   = 16'(SCRUB_INTERVAL);
        end

        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            ivl_q        <= '0;
            word_q       <= '0;
            req_q        <= 1'b0;
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
            err_addr_q   <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            pass_done_q  <= 1'b0;
`ifdef ECC_SCRUB_WRITEBACK_EN
            we_q         <= 1'b0;
            wdata_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            ivl_q        <= ivl_d;
            word_q       <= word_d;
            req_q        <= req_d;
            err_corr_q   <= err_corr_d;
            err_uncorr_q <= err_uncorr_d;
            err_addr_q   <= err_addr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            pass_done_q  <= pass_done_d;
`ifdef ECC_SCRUB_WRITEBACK_EN
            we_q         <= we_d;
            wdata_q      <= wdata_d;
`endif
        end
    end

    assign mem_req    = req_q;
    assign mem_addr   = addr_q;
    assign err_corr   = err_corr_q;
    assign err_uncorr = err_uncorr_q;
    assign err_addr   = err_addr_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
    assign pass_done  = pass_done_q;
`ifdef ECC_SCRUB_WRITEBACK_EN
    assign mem_we     = we_q;
    assign mem_wdata  = wdata_q;
`else
    assign mem_we     = 1'b0;
    assign mem_wdata  = '0;
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: table of read words with hand-computed classification and
// write-back data, plus sequences for disable, counter clear and counter saturation.
module tb_ecc_scrub_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          mem_req;
    logic          mem_gnt = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [38:0]   mem_wdata;
    logic [38:0]   mem_rdata = '0;
    logic          err_corr, err_uncorr, pass_done;
    logic [AW-1:0] err_addr;
    logic [15:0]   corr_cnt, uncorr_cnt;

    ecc_scrub_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .SCRUB_INTERVAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cnt_clr(cnt_clr),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_corr(err_corr),
        .err_uncorr(err_uncorr), .err_addr(err_addr), .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt), .pass_done(pass_done)
    );

    always #5 clk = ~clk;

    // cls: 0 clean, 1 correctable, 2 uncorrectable
    typedef struct packed {
        logic [38:0] rdata;
        logic [1:0]  cls;
        logic [38:0] wdata;
        logic [3:0]  rd_stall;
        logic [3:0]  wr_stall;
    } vec_t;

    vec_t          tbl [10];
    int            n_pass = 0;
    int            n_total = 0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [AW-1:0] m_eaddr = '0;
    logic [15:0]   m_corr = '0;
    logic [15:0]   m_unc = '0;

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_gnt) begin
            if (mem_we) wr_cnt++;
            else        rd_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic run_word(input vec_t v);
        int   r0, w0, n, exp_wr;
        logic wrap;
        n = 0;
        while (mem_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rd_req", mem_req, 1);
        chk("rd_we", mem_we, 0);
        chk("rd_addr", mem_addr, exp_addr);
        r0 = rd_cnt;
        w0 = wr_cnt;
        for (int i = 0; i < int'(v.rd_stall); i++) begin
            @(negedge clk);
            chk("rd_stall_req", mem_req, 1);
            chk("rd_stall_addr", mem_addr, exp_addr);
        end
        mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt   = 1'b0;
        mem_rdata = v.rdata;
        @(negedge clk);
        chk("rd_release", mem_req, 0);
        @(posedge clk);
        #1;
        mem_rdata = 39'h55_5555_5555;
        @(negedge clk);
        chk("early_err", {err_corr, err_uncorr}, 0);
        @(negedge clk);
        chk("err_corr", err_corr, v.cls == 2'd1);
        chk("err_uncorr", err_uncorr, v.cls == 2'd2);
        if (v.cls == 2'd1 && m_corr != 16'hFFFF) m_corr++;
        if (v.cls == 2'd2 && m_unc != 16'hFFFF) m_unc++;
        if (v.cls != 2'd0) m_eaddr = exp_addr;
        chk("corr_cnt", corr_cnt, m_corr);
        chk("uncorr_cnt", uncorr_cnt, m_unc);
        chk("err_addr", err_addr, m_eaddr);
        wrap   = (exp_addr == AW'(DEPTH - 1));
        exp_wr = 0;
`ifdef ECC_SCRUB_WRITEBACK_EN
        if (v.cls == 2'd1) begin
            exp_wr = 1;
            chk("wr_req", mem_req, 1);
            chk("wr_we", mem_we, 1);
            chk("wr_addr", mem_addr, exp_addr);
            chk("wr_data", mem_wdata, v.wdata);
            for (int i = 0; i < int'(v.wr_stall); i++) begin
                @(negedge clk);
                chk("wr_stall_req", {mem_req, mem_we}, 2'b11);
                chk("wr_stall_addr", mem_addr, exp_addr);
                chk("wr_stall_data", mem_wdata, v.wdata);
            end
            mem_gnt = 1'b1;
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            @(negedge clk);
            chk("wr_release", mem_req, 0);
        end else begin
            chk("no_wr_req", mem_req, 0);
        end
`else
        chk("no_wr_req", mem_req, 0);
        chk("we_tied", {mem_we, mem_wdata}, 0);
`endif
        exp_addr = wrap ? '0 : exp_addr + AW'(1);
        chk("pass_done", pass_done, wrap);
        chk("next_addr", mem_addr, exp_addr);
        chk("rd_count", rd_cnt - r0, 1);
        chk("wr_count", wr_cnt - w0, exp_wr);
        $display("word rdata=%h cls=%0d next_addr=%0d corr_cnt=%0d uncorr_cnt=%0d pass_done=%0b",
                 v.rdata, v.cls, exp_addr, corr_cnt, uncorr_cnt, pass_done);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tbl[0] = '{{32'h0000_0000, 7'h00}, 2'd0, 39'h0, 4'd0, 4'd0};
        tbl[1] = '{{32'h0000_0001, 7'h00}, 2'd1, {32'h0, 7'h00}, 4'd5, 4'd5};
        tbl[2] = '{{32'h0000_0000, 7'h02}, 2'd1, {32'h0, 7'h00}, 4'd0, 4'd0};
        tbl[3] = '{{32'h0000_0000, 7'h01}, 2'd1, {32'h0, 7'h00}, 4'd0, 4'd0};
        tbl[4] = '{{32'h0000_0003, 7'h00}, 2'd2, 39'h0, 4'd0, 4'd0};
        tbl[5] = '{{32'h0000_0001, 7'h07}, 2'd0, 39'h0, 4'd1, 4'd0};
        tbl[6] = '{{32'h8000_0000, 7'h00}, 2'd1, {32'h0, 7'h00}, 4'd0, 4'd2};
        tbl[7] = '{{32'h0000_0000, 7'h40}, 2'd1, {32'h0, 7'h00}, 4'd0, 4'd0};
        tbl[8] = '{{32'h0000_0003, 7'h07}, 2'd1, {32'h1, 7'h07}, 4'd0, 4'd0};
        tbl[9] = '{{32'h0000_0000, 7'h7F}, 2'd2, 39'h0, 4'd0, 4'd0};

        repeat (3) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_errs", {err_corr, err_uncorr, pass_done}, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        for (int i = 0; i < 10; i++) run_word(tbl[i]);

        // enable dropped while waiting: request never rises, address held
        enable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("dis_wait_req", mem_req, 0);
            chk("dis_wait_addr", mem_addr, exp_addr);
        end
        enable = 1'b1;
        run_word(tbl[0]);

        // enable dropped while requesting a read without grant
        n = 0;
        while (mem_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dis_rd_req_up", mem_req, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_rd_req_drop", mem_req, 0);
        chk("dis_rd_addr", mem_addr, exp_addr);

        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        m_corr  = '0;
        m_unc   = '0;
        chk("clr_cnts", {corr_cnt, uncorr_cnt}, 0);

        force dut.corr_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.corr_cnt_q;
        @(negedge clk);
        m_corr = 16'hFFFF;
        chk("preload_cnt", corr_cnt, 16'hFFFF);
        chk("idle_req", mem_req, 0);

        enable = 1'b1;
        run_word(tbl[2]);
        run_word(tbl[9]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ecc_scrub_ctrl.md
# ecc_scrub_ctrl

Background scrubber for ECC-protected FIFO storage. It walks every word of the 39-bit SECDED array (32 data bits plus 7 check bits in `ENCODE` layout), re-checks each word through an internal `ENCODE` instance, writes corrected words back, and counts errors. It shares the memory port with the FIFO through a req/gnt handshake and is always lower priority: it never holds the port beyond one granted access.

## Interface
- `DEPTH`, 16: number of words scrubbed; legal range 2..2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, 4: address width.
- `SCRUB_INTERVAL`, 64: idle cycles between consecutive word accesses, 0..65535.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: scrubbing allowed while high.
- `cnt_clr` in 1: synchronous clear of both error counters.
- `mem_req` out 1: port request; held until granted.
- `mem_gnt` in 1: access occurs on the rising edge where `mem_req` and `mem_gnt` are both high.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out `ADDR_WIDTH`: access address.
- `mem_wdata` out 39: write word. [38:7] = data bits 32..1, [6:0] = check bits 6..0.
- `mem_rdata` in 39: read word, valid in the cycle after a granted read.
- `err_corr` out 1: one-cycle pulse, correctable error found.
- `err_uncorr` out 1: one-cycle pulse, uncorrectable error found.
- `err_addr` out `ADDR_WIDTH`: address of the most recent error; holds its value between errors.
- `corr_cnt`, `uncorr_cnt` out 16: saturating error counters.
- `pass_done` out 1: one-cycle pulse when the address wraps from `DEPTH-1` to 0.

## Operation
- **States:** IDLE, WAIT, RD, RDATA, CHK, WR.
- **IDLE → WAIT** when `enable` is high. WAIT loads the interval counter and moves to RD after `SCRUB_INTERVAL` cycles; with an interval of 0 it moves to RD immediately.
- **RD:** `mem_req`=1, `mem_we`=0, `mem_addr`=scrub address. On grant, go to RDATA, which registers `mem_rdata` into the word register. Then go to CHK.
- **CHK:**
  - s[6:1] = ENCODE(data)[6:1] ^ stored check[6:1].
  - p = XOR of all 39 stored bits.
- **Classification:**
  - s=0, p=0: clean.
  - p=1, s=0: error in the overall parity bit. Correctable.
  - p=1, s a power of two: error in a check bit. Correctable; the word is rewritten with re-encoded check bits.
  - p=1, s in 3..38 and not a power of two: data error. Correctable. Flip data bit (s − number of powers of two ≤ s); e.g. s=3 → bit 1, s=5 → bit 2, s=38 → bit 32.
  - p=1, s > 38: uncorrectable.
  - p=0, s≠0: double error, uncorrectable.
- **After CHK:**
  - Correctable: go to WR. `mem_req`=1, `mem_we`=1, `mem_wdata` = {corrected data, ENCODE(corrected data)}, same address. Hold until granted.
  - Otherwise: advance the address and go to WAIT.
- **Error reporting:** in the cycle after CHK, pulse `err_corr` or `err_uncorr`, load `err_addr`, and increment the matching counter. Counters saturate at 16'hFFFF. `cnt_clr` wins over a same-cycle increment. Uncorrectable words are never written.
- **Address advance:** `DEPTH-1` → 0 with a `pass_done` pulse, otherwise +1.
- **`enable` low:**
  - In WAIT, or in RD before grant: drop `mem_req` in the next cycle, go to IDLE, keep the address.
  - After a granted read: the word completes, including any WR, and then the block goes to IDLE.
- **Reset:** state IDLE, address 0, interval counter 0, all outputs 0.
- **Reset mid-transaction:** abandons the access and issues no write.

## Timing
- **Clean word, grant in first RD cycle:** RD (cycle n) → RDATA (n+1) → CHK (n+2) → WAIT (n+3).
- **Correctable word:** `err_corr` and WR request both appear in cycle n+3. With immediate grant the write occurs at the end of n+3 and the block is in WAIT at n+4.
- **Output stability:** `mem_addr`, `mem_we` and `mem_wdata` are registered and stable for the whole time `mem_req` is high.
- **Request release:** `mem_req` falls in the cycle after its grant.
- **Word period, no stalls:** `SCRUB_INTERVAL` + 4 cycles for a clean word, +5 for a corrected word.

## Configuration
- **`ECC_SCRUB_WRITEBACK_EN` defined:** correctable words are written back as described above.
- **Not defined:** report-only mode. The WR state is not built, `mem_we` is tied to 0, and `mem_wdata` is tied to 0. Errors are still pulsed and counted, and the address advances directly after CHK.

## Test plan
- **Clean word:** rdata {32'h0, 7'h00}, `SCRUB_INTERVAL`=0, immediate grant → no error pulses, no write, address 0 → 1.
- **Single data error:** rdata {32'h0000_0001, 7'h00} → s=3, p=1. Expect `err_corr`, `corr_cnt`=1, and a write at the same address with wdata {32'h0, 7'h00}.
- **Check/parity-bit errors:**
  - rdata {32'h0, 7'h02} → corrected, write {32'h0, 7'h00}.
  - rdata {32'h0, 7'h01} → corrected, write {32'h0, 7'h00}.
- **Double error:** rdata {32'h0000_0003, 7'h00} → s=6, p=0. Expect `err_uncorr`, `uncorr_cnt`=1, no write, address advances.
- **Grant stall:** hold `mem_gnt` low for 5 cycles in RD and again in WR → `mem_req` and address/data stay stable throughout, and exactly one read and one write occur.
- **Wrap, disable, saturation:**
  - `DEPTH`=4: the fourth word produces a `pass_done` pulse and the address returns to 0.
  - `enable` dropped in WAIT → IDLE with the address held.
  - Preload 16'hFFFF in `corr_cnt` plus one more error → counter stays at 16'hFFFF.
